// File: rtl/serial_to_parallel_register_pkg.sv
// Shared definitions for the serial-to-parallel word assembler:
// the capture FSM encoding and the width of the bit counter.
package serial_to_parallel_register_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must be able to hold the value WIDTH itself once a word completes
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_to_parallel_register_shift_register_wide.sv
// WIDTH-bit serial-in shifter. Exposes the value it would hold after the
// next shift so the parent can latch a completed word on the final bit.
module shift_register_wide
  import serial_to_parallel_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             shift_en,
  input  logic             msb_first,
  input  logic             din,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] q;

  // Next value: shift left with din into bit 0, or right with din into the top bit
  always_comb begin
    q_next = q;
    if (msb_first) begin
      q_next = {q[WIDTH-2:0], din};
    end else begin
      q_next = {din, q[WIDTH-1:1]};
    end
  end

  // Register the shifted value; clear wins over shifting
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/serial_to_parallel_register.sv
// Assembles WIDTH serial bits from an upstream flip-flop into a word,
// presents it as true/complement outputs under a Valid/Ack handshake,
// and flags Start requests that arrive while a word is in flight.
module serial_to_parallel_register
  import serial_to_parallel_register_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                           Ck,
  input  logic                           RstN,
  input  logic                           Din,
  input  logic                           Start,
  input  logic                           Ack,
  output logic [WIDTH-1:0]               Word,
  output logic [WIDTH-1:0]               WordN,
  output logic                           Valid,
  output logic                           Busy,
  output logic [count_width(WIDTH)-1:0]  Count,
  output logic                           Overrun
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic             shift_en;
  logic             count_clr;
  logic             load_word;
  logic             set_overrun;
  logic [WIDTH-1:0] shift_next;

  shift_register_wide #(
    .WIDTH(WIDTH)
  ) u_shift (
    .clk      (Ck),
    .clear_n  (RstN),
    .shift_en (shift_en),
    .msb_first(MSB_FIRST),
    .din      (Din),
    .q_next   (shift_next)
  );

  // State register; reset returns to IDLE from anywhere, even mid-capture
  always_ff @(posedge Ck) begin
    if (!RstN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode; a Start that cannot be honoured only raises Overrun
  always_comb begin
    next_state  = state;
    shift_en    = 1'b0;
    count_clr   = 1'b0;
    load_word   = 1'b0;
    set_overrun = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          next_state = SHIFT;
          count_clr  = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (Start) begin
          set_overrun = 1'b1;
        end
        if (Count == CW'(WIDTH - 1)) begin
          load_word  = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (Ack) begin
          count_clr  = 1'b1;
          next_state = Start ? SHIFT : IDLE;
        end else if (Start) begin
          set_overrun = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bit counter: cleared when a capture is framed, bumped on every sampled bit
  always_ff @(posedge Ck) begin
    if (!RstN) begin
      Count <= '0;
    end else if (count_clr) begin
      Count <= '0;
    end else if (shift_en) begin
      Count <= Count + CW'(1);
    end
  end

  // Output word only changes when the final bit lands, so it is stable while shifting
  always_ff @(posedge Ck) begin
    if (!RstN) begin
      Word  <= '0;
      WordN <= '1;
    end else if (load_word) begin
      Word  <= shift_next;
      WordN <= ~shift_next;
    end
  end

  // Sticky protocol-error flag, only reset can clear it
  always_ff @(posedge Ck) begin
    if (!RstN) begin
      Overrun <= 1'b0;
    end else if (set_overrun) begin
      Overrun <= 1'b1;
    end
  end

  assign Busy  = (state == SHIFT);
  assign Valid = (state == HOLD);

endmodule
